// File: rtl/flex_elastic_buffer.sv
// flex_elastic_buffer: DEPTH-entry ring-buffer FIFO with valid/ready handshakes
// on both sides. in_ready and out_valid come from the registered occupancy
// count only, so there is no combinational path between the two sides and no
// empty bypass. The minimum latency from push to visibility is one cycle.
module flex_elastic_buffer #(
    parameter int NUM_BITS = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [NUM_BITS-1:0]        in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [NUM_BITS-1:0]        out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                push;
    logic                pop;

    // Status flags are derived from the registered count alone.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    // A flush overrides any transfer in the same cycle.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Storage: cleared on reset, written at wr_ptr on push.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem <= '{default: '0};
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers advance on transfer and wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_flex_elastic_buffer.sv
// Directed-vector bench for flex_elastic_buffer (NUM_BITS=32, DEPTH=4).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_flex_elastic_buffer;

    logic        clk;
    logic        n_rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  count;

    int n_checks;
    int n_pass;

    flex_elastic_buffer #(
        .NUM_BITS (32),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one word with out_ready low.
    task automatic push_word(input logic [31:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_rst     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_out_data", out_data, 0);
        #21;
        n_rst = 1'b1;
        tick();

        // Single push, one-cycle latency
        in_valid = 1'b1;
        in_data  = 32'hA5A5_A5A5;
        check("no_bypass_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 32'hA5A5_A5A5);
        check("single_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drain_count", count, 0);
        check("single_drain_valid", out_valid, 0);

        // Empty: out_ready ignored, no underflow
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_no_underflow", count, 0);

        // Fill past full: 5th word refused
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_head", out_data, 1);
        tick();
        check("stall_head_stable", out_data, 1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", out_data, 32'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("drain_empty_count", count, 0);

        // Full with push and pop offered together: pop only
        for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(i));
        check("full2_count", count, 4);
        in_valid  = 1'b1;
        in_data   = 32'h14;
        out_ready = 1'b1;
        tick();
        check("full_pop_only_count", count, 3);
        check("full_pop_in_ready", in_ready, 1);
        check("full_pop_head", out_data, 32'h11);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("refill_count", count, 4);
        for (int i = 1; i <= 4; i++) begin
            check("drain2_order", out_data, 32'h10 + 32'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("drain2_empty", out_valid, 0);

        // Streaming 10 words with both sides always ready
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(k);
            tick();
            check("stream_count", count, 1);
            check("stream_data", out_data, 32'h100 + 32'(k));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_end_count", count, 0);

        // Flush overrides simultaneous push and pop
        for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i));
        check("preflush_count", count, 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        push_word(32'h77);
        check("postflush_data", out_data, 32'h77);
        check("postflush_count", count, 1);

        // Asynchronous reset mid-operation
        push_word(32'h78);
        check("prerst_count", count, 2);
        #3;
        n_rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_count", count, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_in_ready", in_ready, 1);
        #2;
        n_rst = 1'b1;
        push_word(32'hBEEF);
        check("postrst_count", count, 1);
        check("postrst_data", out_data, 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
